// File: rtl/ctr_drbg_generate.sv
// rtl/ctr_drbg_generate.sv - CTR_DRBG generate sequencer driving external AES and update engines
module ctr_drbg_generate #(
    parameter logic [47:0] RESEED_INTERVAL = 48'd1048576
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [255:0] key_in,
    input  logic [127:0] v_in,
    input  logic [7:0]   num_blocks,
    input  logic [383:0] additional_input,
    output logic         aes_start,
    output logic [255:0] aes_key,
    output logic [127:0] aes_block_in,
    input  logic         aes_done,
    input  logic [127:0] aes_block_out,
    output logic         out_valid,
    output logic [127:0] out_data,
    input  logic         out_ready,
    output logic         upd_start,
    output logic [383:0] upd_provided_data,
    output logic [255:0] upd_key_in,
    output logic [127:0] upd_v_in,
    input  logic         upd_done,
    input  logic [255:0] upd_key_out,
    input  logic [127:0] upd_v_out,
    output logic [255:0] key_out,
    output logic [127:0] v_out,
    output logic         busy,
    output logic         done,
    output logic         reseed_required,
    output logic [47:0]  reseed_counter
);

    typedef enum logic [2:0] {
        IDLE, INC, AES_REQ, AES_WAIT, OUT, UPD, FIN
    } state_t;

    state_t       state, state_nxt;
    logic [255:0] k;
    logic [127:0] v;
    logic [7:0]   remaining;
    logic [383:0] addl;
    logic [127:0] data_q;
    logic [47:0]  cnt;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:     if (start) state_nxt = (num_blocks != 8'd0) ? INC : FIN;
            INC:      state_nxt = AES_REQ;
            AES_REQ:  state_nxt = AES_WAIT;
            AES_WAIT: if (aes_done) state_nxt = OUT;
            // remaining still holds the pre-decrement count on the handshake cycle
            OUT:      if (out_ready) state_nxt = (remaining > 8'd1) ? INC : UPD;
            UPD:      if (upd_done) state_nxt = FIN;
            FIN:      state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            k         <= '0;
            v         <= '0;
            remaining <= '0;
            addl      <= '0;
            data_q    <= '0;
            cnt       <= '0;
        end else begin
            state <= state_nxt;
            unique case (state)
                IDLE: begin
                    if (start && num_blocks != 8'd0) begin
                        k         <= key_in;
                        v         <= v_in;
                        remaining <= num_blocks;
                        addl      <= additional_input;
                    end
                end
                INC:      v <= v + 128'd1;
                AES_WAIT: if (aes_done) data_q <= aes_block_out;
                OUT:      if (out_ready) remaining <= remaining - 8'd1;
                UPD: begin
                    if (upd_done) begin
                        k <= upd_key_out;
                        v <= upd_v_out;
                    end
                end
                FIN:      if (cnt != '1) cnt <= cnt + 48'd1;
                default: ;
            endcase
        end
    end

    assign aes_start         = (state == AES_REQ);
    assign aes_key           = k;
    assign aes_block_in      = v;
    assign out_valid         = (state == OUT);
    assign out_data          = data_q;
    assign upd_start         = (state == UPD);
    assign upd_provided_data = addl;
    assign upd_key_in        = k;
    assign upd_v_in          = v;
    assign key_out           = k;
    assign v_out             = v;
    assign busy              = (state != IDLE);
    assign done              = (state == FIN);
    assign reseed_counter    = cnt;
    assign reseed_required   = (cnt >= RESEED_INTERVAL);

endmodule

// File: tb/tb_ctr_drbg_generate.sv
// tb/tb_ctr_drbg_generate.sv - scoreboard bench for ctr_drbg_generate with AES/update responders
module tb_ctr_drbg_generate;
    localparam logic [47:0] RI = 48'd4;

    logic         clk = 1'b0;
    logic         rst, start;
    logic [255:0] key_in;
    logic [127:0] v_in;
    logic [7:0]   num_blocks;
    logic [383:0] additional_input;
    logic         aes_start, aes_done;
    logic [255:0] aes_key;
    logic [127:0] aes_block_in, aes_block_out;
    logic         out_valid, out_ready;
    logic [127:0] out_data;
    logic         upd_start, upd_done;
    logic [383:0] upd_provided_data;
    logic [255:0] upd_key_in, upd_key_out;
    logic [127:0] upd_v_in, upd_v_out;
    logic [255:0] key_out;
    logic [127:0] v_out;
    logic         busy, done, reseed_required;
    logic [47:0]  reseed_counter;

    ctr_drbg_generate #(.RESEED_INTERVAL(RI)) dut (
        .clk(clk), .rst(rst), .start(start), .key_in(key_in), .v_in(v_in),
        .num_blocks(num_blocks), .additional_input(additional_input),
        .aes_start(aes_start), .aes_key(aes_key), .aes_block_in(aes_block_in),
        .aes_done(aes_done), .aes_block_out(aes_block_out),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .upd_start(upd_start), .upd_provided_data(upd_provided_data),
        .upd_key_in(upd_key_in), .upd_v_in(upd_v_in), .upd_done(upd_done),
        .upd_key_out(upd_key_out), .upd_v_out(upd_v_out),
        .key_out(key_out), .v_out(v_out), .busy(busy), .done(done),
        .reseed_required(reseed_required), .reseed_counter(reseed_counter)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int ndone_exp = 0;
    int aes_lat = 3, upd_lat = 2, ready_mode = 2;
    bit upd_fixed = 1'b0;

    logic [255:0] m_k = '0;
    logic [127:0] m_v = '0;
    logic [47:0]  m_cnt = '0;

    logic [255:0] q_aes_k[$];
    logic [127:0] q_aes_in[$];
    logic [127:0] q_out[$];
    logic [383:0] q_upd_p[$];
    logic [255:0] q_upd_k[$];
    logic [127:0] q_upd_v[$];
    logic [255:0] q_done_k[$];
    logic [127:0] q_done_v[$];
    logic [47:0]  q_done_c[$];

    task automatic chk(input string name, input logic [383:0] act, input logic [383:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic miss(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got event expected none", name);
    endtask

    function automatic logic [255:0] r256();
        logic [255:0] r = '0;
        for (int i = 0; i < 8; i++) r = {r[223:0], 32'($urandom)};
        return r;
    endfunction

    function automatic logic [127:0] r128();
        logic [127:0] r = '0;
        for (int i = 0; i < 4; i++) r = {r[95:0], 32'($urandom)};
        return r;
    endfunction

    // Stand-in block cipher: any keyed bijection-like mix is enough to track data flow
    function automatic logic [127:0] aes_ref(input logic [255:0] kk, input logic [127:0] b);
        return ({b[62:0], b[127:63]} ^ kk[255:128]) + (b ^ kk[127:0])
               + 128'h9e3779b97f4a7c15f39cc0605cedc834;
    endfunction

    function automatic logic [255:0] upd_k_ref(input logic [383:0] p, input logic [255:0] kk,
                                               input logic [127:0] vv);
        return p[255:0] ^ {kk[127:0], kk[255:128]} ^ {vv, vv};
    endfunction

    function automatic logic [127:0] upd_v_ref(input logic [383:0] p, input logic [127:0] vv);
        return (p[383:256] ^ vv) + 128'd7;
    endfunction

    // Reference: a generate call consumes n counter values, then one update, then bumps the call count
    task automatic model_gen(input logic [255:0] k0, input logic [127:0] v0,
                             input logic [7:0] n, input logic [383:0] p);
        logic [255:0] kk;
        logic [127:0] vv;
        kk = (n != 0) ? k0 : m_k;
        vv = (n != 0) ? v0 : m_v;
        for (int i = 0; i < int'(n); i++) begin
            vv = vv + 128'd1;
            q_aes_k.push_back(kk);
            q_aes_in.push_back(vv);
            q_out.push_back(aes_ref(kk, vv));
        end
        if (n != 0) begin
            q_upd_p.push_back(p);
            q_upd_k.push_back(kk);
            q_upd_v.push_back(vv);
            if (upd_fixed) begin
                kk = {32{8'hA5}};
                vv = {16{8'h5A}};
            end else begin
                logic [255:0] nk;
                nk = upd_k_ref(p, kk, vv);
                vv = upd_v_ref(p, vv);
                kk = nk;
            end
        end
        q_done_k.push_back(kk);
        q_done_v.push_back(vv);
        q_done_c.push_back(m_cnt);
        m_k = kk;
        m_v = vv;
        if (m_cnt != '1) m_cnt = m_cnt + 48'd1;
    endtask

    task automatic flush_model();
        q_aes_k.delete(); q_aes_in.delete(); q_out.delete();
        q_upd_p.delete(); q_upd_k.delete(); q_upd_v.delete();
        q_done_k.delete(); q_done_v.delete(); q_done_c.delete();
        m_k = '0; m_v = '0; m_cnt = '0;
    endtask

    task automatic issue(input logic [255:0] k0, input logic [127:0] v0,
                         input logic [7:0] n, input logic [383:0] p);
        key_in = k0; v_in = v0; num_blocks = n; additional_input = p; start = 1'b1;
        model_gen(k0, v0, n, p);
        @(posedge clk); #1;
        start = 1'b0;
        key_in = r256(); v_in = r128(); num_blocks = 8'($urandom); additional_input = {r128(), r256()};
    endtask

    task automatic wait_done();
        int t = 0;
        while (done_cnt < ndone_exp && t < 3000) begin
            @(posedge clk); #1;
            t++;
        end
        if (done_cnt < ndone_exp) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: got %0d dones expected %0d", done_cnt, ndone_exp);
        end
    endtask

    task automatic run_gen(input logic [255:0] k0, input logic [127:0] v0,
                           input logic [7:0] n, input logic [383:0] p);
        issue(k0, v0, n, p);
        ndone_exp++;
        wait_done();
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_aes_start"}, aes_start, 0);
        chk({tag, "_upd_start"}, upd_start, 0);
        chk({tag, "_reseed_required"}, reseed_required, 0);
        chk({tag, "_key_out"}, key_out, 0);
        chk({tag, "_v_out"}, v_out, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_reseed_counter"}, reseed_counter, 0);
    endtask

    // Scoreboard monitor
    bit prev_upd = 1'b0, prev_wait = 1'b0;
    logic [127:0] held = '0;
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_upd = 1'b0;
                prev_wait = 1'b0;
            end else begin
                if (aes_start) begin
                    if (q_aes_in.size() == 0) miss("unexpected_aes_start");
                    else begin
                        chk("aes_block_in", aes_block_in, q_aes_in.pop_front());
                        chk("aes_key", aes_key, q_aes_k.pop_front());
                    end
                end
                if (out_valid && prev_wait) chk("out_data_stable", out_data, held);
                if (out_valid && out_ready) begin
                    if (q_out.size() == 0) miss("unexpected_out_handshake");
                    else chk("out_data", out_data, q_out.pop_front());
                end
                if (upd_start && !prev_upd) begin
                    if (q_upd_p.size() == 0) miss("unexpected_upd_start");
                    else begin
                        chk("upd_provided_data", upd_provided_data, q_upd_p.pop_front());
                        chk("upd_key_in", upd_key_in, q_upd_k.pop_front());
                        chk("upd_v_in", upd_v_in, q_upd_v.pop_front());
                    end
                end
                if (done) begin
                    if (q_done_k.size() == 0) miss("unexpected_done");
                    else begin
                        logic [47:0] c;
                        c = q_done_c.pop_front();
                        chk("done_key_out", key_out, q_done_k.pop_front());
                        chk("done_v_out", v_out, q_done_v.pop_front());
                        chk("done_reseed_counter", reseed_counter, c);
                        chk("done_reseed_required", reseed_required, c >= RI);
                    end
                    done_cnt++;
                end
                prev_upd  = upd_start;
                prev_wait = out_valid && !out_ready;
                held      = out_data;
            end
        end
    end

    // AES engine responder
    initial begin
        logic [127:0] blk;
        aes_done = 1'b0;
        aes_block_out = '0;
        forever begin
            @(posedge clk); #1;
            if (aes_start && !rst) begin
                blk = aes_ref(aes_key, aes_block_in);
                repeat (aes_lat) begin @(posedge clk); #1; end
                aes_block_out = blk;
                aes_done = 1'b1;
                @(posedge clk); #1;
                aes_done = 1'b0;
                aes_block_out = r128();
            end
        end
    end

    // Update engine responder
    initial begin
        logic [255:0] kk;
        logic [127:0] vv;
        upd_done = 1'b0;
        upd_key_out = '0;
        upd_v_out = '0;
        forever begin
            @(posedge clk); #1;
            if (upd_start && !rst) begin
                kk = upd_fixed ? {32{8'hA5}} : upd_k_ref(upd_provided_data, upd_key_in, upd_v_in);
                vv = upd_fixed ? {16{8'h5A}} : upd_v_ref(upd_provided_data, upd_v_in);
                repeat (upd_lat) begin @(posedge clk); #1; end
                upd_key_out = kk;
                upd_v_out = vv;
                upd_done = 1'b1;
                @(posedge clk); #1;
                upd_done = 1'b0;
            end
        end
    end

    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       out_ready = ($urandom % 3) != 0;
                1:       out_ready = 1'b0;
                default: out_ready = 1'b1;
            endcase
        end
    end

    initial begin
        int t;
        rst = 1'b1; start = 1'b0; key_in = '0; v_in = '0; num_blocks = '0; additional_input = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // Basic: key 0, v 0, two blocks
        run_gen('0, '0, 8'd2, {r128(), r256()});
        chk("basic_reseed_counter", reseed_counter, m_cnt);

        // Back-pressure
        ready_mode = 1;
        issue(r256(), r128(), 8'd2, {r128(), r256()});
        ndone_exp++;
        t = 0;
        while (!out_valid && t < 100) begin @(posedge clk); #1; t++; end
        chk("bp_reached_out", out_valid, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_no_aes_start", aes_start, 0);
        end
        @(posedge clk); #1;
        ready_mode = 2;
        wait_done();

        // Counter wrap
        run_gen(r256(), '1, 8'd1, {r128(), r256()});

        // Zero request: state unchanged, no engine activity
        run_gen(r256(), r128(), 8'd0, {r128(), r256()});

        // Update handoff with fixed engine result
        upd_fixed = 1'b1; upd_lat = 5;
        run_gen(r256(), r128(), 8'd2, {6{64'h0123456789abcdef}});
        upd_fixed = 1'b0; upd_lat = 2;

        // Start while busy must not re-latch
        ready_mode = 0;
        issue(r256(), r128(), 8'd3, {r128(), r256()});
        ndone_exp++;
        repeat (4) @(posedge clk);
        #1;
        key_in = r256(); v_in = r128(); num_blocks = 8'd9; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done();

        // Randomized calls
        for (int i = 0; i < 12; i++) begin
            aes_lat = $urandom_range(1, 5);
            upd_lat = $urandom_range(1, 4);
            run_gen(r256(), ($urandom % 3 == 0) ? ~128'd1 : r128(),
                    8'($urandom_range(0, 5)), {r128(), r256()});
        end

        // Reset during AES_WAIT; the late aes_done must be ignored
        ready_mode = 2;
        aes_lat = 6;
        issue(r256(), r128(), 8'd3, {r128(), r256()});
        t = 0;
        while (!aes_start && t < 100) begin @(posedge clk); #1; t++; end
        chk("rst_reached_aes_req", aes_start, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_vals("midrst");
        flush_model();
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("late_aes_done_out_data", out_data, 0);
        chk("late_aes_done_busy", busy, 0);
        chk("late_aes_done_out_valid", out_valid, 0);
        @(posedge clk); #1;
        aes_lat = 2;
        run_gen(r256(), r128(), 8'd1, {r128(), r256()});
        chk("final_reseed_counter", reseed_counter, m_cnt);
        chk("final_queues_empty", q_out.size() + q_aes_in.size() + q_done_k.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
